// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, Status/Cause bit
// positions and the redirect state machine encoding.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;
  localparam logic [4:0] EXC_DZ  = 5'd15;

  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LO   = 8;
  localparam int CAUSE_EXC_LO   = 2;
  localparam int CAUSE_IP_LO    = 8;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } cp0_state_e;

  // Reserved source encoding 11 is reported as an undefined instruction.
  function automatic logic [4:0] exc_code(input logic [1:0] sel);
    case (sel)
      2'b00:   exc_code = EXC_OV;
      2'b10:   exc_code = EXC_DZ;
      default: exc_code = EXC_RI;
    endcase
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with a sticky pending flag that only a Compare
// write clears.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pending_o
);

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q <= count_we ? wdata : count_q + 32'd1;
      // A Compare write wins over a match seen in the same cycle.
      if (compare_we) begin
        compare_q <= wdata;
        pending_q <= 1'b0;
      end else if (count_q == compare_q) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 responder: Status/Cause/EPC state, event arbitration and the
// one-cycle PC redirect towards the vector or back to EPC.
module cp0_exception_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR  = 32'h8000_0180,
  parameter logic [31:0] RESET_STATUS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_pc_i,
  input  logic        exception_i,
  input  logic [1:0]  cause_sel_i,
  input  logic        cp0_write_i,
  input  logic [4:0]  cp0_addr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic        eret_i,
  input  logic        irq_i,
  output logic [31:0] cp0_rdata_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        exl_o,
  output logic        timer_irq_o
);

  logic        status_ie_q;
  logic        status_exl_q;
  logic [7:0]  status_im_q;
  logic [4:0]  exc_code_q;
  logic [1:0]  ip_sw_q;
  logic [31:0] epc_q;
  logic        irq_meta_q;
  logic        irq_sync_q;

  cp0_state_e  state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_pending;
  logic [7:0]  ip;
  logic        in_run;
  logic        take_exc;
  logic        take_int;
  logic        take_eret;
  logic        any_event;
  logic        mtc0_we;

  assign ip        = {timer_pending, 4'b0000, irq_sync_q, ip_sw_q};
  assign in_run    = (state_q == ST_RUN);
  assign take_exc  = in_run & instr_valid_i & exception_i;
  assign take_int  = in_run & instr_valid_i & ~exception_i & status_ie_q &
                     ~status_exl_q & (|(ip & status_im_q));
  assign take_eret = in_run & eret_i & ~take_exc & ~take_int;
  assign any_event = take_exc | take_int | take_eret;
  assign mtc0_we   = cp0_write_i & ~any_event;

  cp0_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_we   (mtc0_we && (cp0_addr_i == CP0_COUNT)),
    .compare_we (mtc0_we && (cp0_addr_i == CP0_COMPARE)),
    .wdata      (cp0_wdata_i),
    .count_o    (count),
    .compare_o  (compare),
    .pending_o  (timer_pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_meta_q <= 1'b0;
      irq_sync_q <= 1'b0;
    end else begin
      irq_meta_q <= irq_i;
      irq_sync_q <= irq_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_ie_q  <= RESET_STATUS[STATUS_IE_BIT];
      status_exl_q <= RESET_STATUS[STATUS_EXL_BIT];
      status_im_q  <= RESET_STATUS[STATUS_IM_LO +: 8];
      exc_code_q   <= '0;
      ip_sw_q      <= '0;
      epc_q        <= '0;
    end else if (take_exc || take_int) begin
      exc_code_q   <= take_exc ? exc_code(cause_sel_i) : EXC_INT;
      status_exl_q <= 1'b1;
      // Nested exceptions keep the return address of the outer one.
      if (!status_exl_q) epc_q <= instr_pc_i;
    end else if (take_eret) begin
      status_exl_q <= 1'b0;
    end else if (mtc0_we) begin
      case (cp0_addr_i)
        CP0_STATUS: begin
          status_ie_q  <= cp0_wdata_i[STATUS_IE_BIT];
          status_exl_q <= cp0_wdata_i[STATUS_EXL_BIT];
          status_im_q  <= cp0_wdata_i[STATUS_IM_LO +: 8];
        end
        CP0_CAUSE: ip_sw_q <= cp0_wdata_i[CAUSE_IP_LO +: 2];
        CP0_EPC:   epc_q   <= cp0_wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    redirect_o    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (any_event) begin
          state_d       = ST_REDIRECT;
          redirect_pc_d = take_eret ? epc_q : VECTOR_ADDR;
        end
      end
      ST_REDIRECT: begin
        redirect_o = 1'b1;
        state_d    = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cp0_rdata_o = '0;
    case (cp0_addr_i)
      CP0_COUNT:   cp0_rdata_o = count;
      CP0_COMPARE: cp0_rdata_o = compare;
      CP0_STATUS:  cp0_rdata_o = {16'h0000, status_im_q, 6'b000000,
                                  status_exl_q, status_ie_q};
      CP0_CAUSE:   cp0_rdata_o = {16'h0000, ip, 1'b0, exc_code_q, 2'b00};
      CP0_EPC:     cp0_rdata_o = epc_q;
      default:     cp0_rdata_o = '0;
    endcase
  end

  assign redirect_pc_o = redirect_pc_q;
  assign exl_o         = status_exl_q;
  assign timer_irq_o   = timer_pending;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed and randomized bench for cp0_exception_unit against a word-level
// reference model of the CP0 register file and redirect behaviour.
module tb_cp0_exception_unit;

  localparam logic [31:0] VEC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid_i = 1'b0;
  logic [31:0] instr_pc_i = '0;
  logic        exception_i = 1'b0;
  logic [1:0]  cause_sel_i = '0;
  logic        cp0_write_i = 1'b0;
  logic [4:0]  cp0_addr_i = '0;
  logic [31:0] cp0_wdata_i = '0;
  logic        eret_i = 1'b0;
  logic        irq_i = 1'b0;
  logic [31:0] cp0_rdata_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        exl_o;
  logic        timer_irq_o;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  cp0_exception_unit #(.VECTOR_ADDR(VEC), .RESET_STATUS(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid_i),
    .instr_pc_i(instr_pc_i), .exception_i(exception_i),
    .cause_sel_i(cause_sel_i), .cp0_write_i(cp0_write_i),
    .cp0_addr_i(cp0_addr_i), .cp0_wdata_i(cp0_wdata_i), .eret_i(eret_i),
    .irq_i(irq_i), .cp0_rdata_o(cp0_rdata_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .exl_o(exl_o), .timer_irq_o(timer_irq_o)
  );

  always #5 clk = ~clk;

  // Reference model state, kept as whole architectural words.
  logic [31:0] m_status, m_epc, m_count, m_compare, m_rpc;
  logic [4:0]  m_code;
  logic [1:0]  m_ipsw;
  logic [1:0]  m_sync;
  logic        m_pend, m_redir;

  function automatic logic [7:0] m_ip();
    return {m_pend, 4'b0000, m_sync[1], m_ipsw};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return {16'h0, m_ip(), 1'b0, m_code, 2'b00};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_status = 32'h0; m_epc = 32'h0; m_count = 32'h0; m_compare = 32'h0;
      m_rpc = 32'h0; m_code = 5'd0; m_ipsw = 2'b00; m_sync = 2'b00;
      m_pend = 1'b0; m_redir = 1'b0;
    end else begin
      logic exc, intr, er, wr, run, exl_old;
      logic [31:0] cnt_old, cmp_old, epc_old;
      run     = !m_redir;
      exl_old = m_status[1];
      cnt_old = m_count; cmp_old = m_compare; epc_old = m_epc;
      exc  = run && instr_valid_i && exception_i;
      intr = run && instr_valid_i && !exception_i && m_status[0] && !exl_old &&
             ((m_ip() & m_status[15:8]) != 8'h00);
      er   = run && eret_i && !exc && !intr;
      wr   = cp0_write_i && !(exc || intr || er);
      m_count = cnt_old + 32'd1;
      if (cnt_old == cmp_old) m_pend = 1'b1;
      m_redir = exc || intr || er;
      if (exc) begin
        m_code = (cause_sel_i == 2'd0) ? 5'd12 : (cause_sel_i == 2'd2) ? 5'd15 : 5'd10;
        if (!exl_old) m_epc = instr_pc_i;
        m_status = m_status | 32'h2;
        m_rpc = VEC;
      end else if (intr) begin
        m_code = 5'd0;
        m_epc = instr_pc_i;
        m_status = m_status | 32'h2;
        m_rpc = VEC;
      end else if (er) begin
        m_status = m_status & ~32'h2;
        m_rpc = epc_old;
      end
      if (wr) begin
        case (cp0_addr_i)
          5'd9:  m_count = cp0_wdata_i;
          5'd11: begin m_compare = cp0_wdata_i; m_pend = 1'b0; end
          5'd12: m_status = (m_status & ~32'h0000_FF03) | (cp0_wdata_i & 32'h0000_FF03);
          5'd13: m_ipsw = cp0_wdata_i[9:8];
          5'd14: m_epc = cp0_wdata_i;
          default: ;
        endcase
      end
      m_sync = {m_sync[0], irq_i};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("redirect_o", {31'b0, redirect_o}, {31'b0, m_redir});
      chk("redirect_pc_o", redirect_pc_o, m_rpc);
      chk("exl_o", {31'b0, exl_o}, {31'b0, m_status[1]});
      chk("timer_irq_o", {31'b0, timer_irq_o}, {31'b0, m_pend});
      chk("cp0_rdata_o", cp0_rdata_o, m_read(cp0_addr_i));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid_i = 1'b0; exception_i = 1'b0; cp0_write_i = 1'b0; eret_i = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    instr_valid_i = 1'b1; cp0_write_i = 1'b1; cp0_addr_i = a; cp0_wdata_i = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    cp0_addr_i = a;
    #1;
    v = cp0_rdata_o;
  endtask

  initial begin
    logic [31:0] v;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst redirect_o", {31'b0, redirect_o}, 32'h0);
    chk("rst redirect_pc_o", redirect_pc_o, 32'h0);
    chk("rst exl_o", {31'b0, exl_o}, 32'h0);
    rd(5'd12, v); chk("rst status", v, 32'h0);
    rd(5'd13, v); chk("rst cause", v, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // overflow at EXL=0
    instr_valid_i = 1'b1; exception_i = 1'b1; cause_sel_i = 2'd0; instr_pc_i = 32'h0040_0010;
    tick(); idle();
    chk("ov redirect_o", {31'b0, redirect_o}, 32'h1);
    chk("ov target", redirect_pc_o, 32'h8000_0180);
    chk("ov exl", {31'b0, exl_o}, 32'h1);
    rd(5'd14, v); chk("ov epc", v, 32'h0040_0010);
    rd(5'd13, v); chk("ov exccode", {27'b0, v[6:2]}, 32'd12);
    tick();

    // nested divide-by-zero, then eret
    instr_valid_i = 1'b1; exception_i = 1'b1; cause_sel_i = 2'd2; instr_pc_i = 32'h8000_0190;
    tick(); idle();
    chk("nest target", redirect_pc_o, 32'h8000_0180);
    rd(5'd14, v); chk("nest epc kept", v, 32'h0040_0010);
    rd(5'd13, v); chk("nest exccode", {27'b0, v[6:2]}, 32'd15);
    tick();
    instr_valid_i = 1'b1; eret_i = 1'b1;
    tick(); idle();
    chk("eret redirect_o", {31'b0, redirect_o}, 32'h1);
    chk("eret target", redirect_pc_o, 32'h0040_0010);
    chk("eret exl", {31'b0, exl_o}, 32'h0);
    tick();

    // undefined instruction drops a same-cycle Status write
    exception_i = 1'b1; cause_sel_i = 2'd1; instr_pc_i = 32'h0040_0020;
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd13, v); chk("ri exccode", {27'b0, v[6:2]}, 32'd10);
    rd(5'd12, v); chk("ri status im", {24'b0, v[15:8]}, 32'h0);
    tick();
    instr_valid_i = 1'b1; eret_i = 1'b1; tick(); idle(); tick();

    // timer interrupt
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'd20);
    mtc0(5'd12, 32'h0000_8001);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (timer_irq_o) seen = 1'b1;
      else tick();
    end
    chk("timer rose", {31'b0, timer_irq_o}, 32'h1);
    rd(5'd9, v); chk("timer count", v, 32'd21);
    instr_valid_i = 1'b1; instr_pc_i = 32'h0040_0100;
    tick(); idle();
    chk("tint redirect_o", {31'b0, redirect_o}, 32'h1);
    rd(5'd14, v); chk("tint epc", v, 32'h0040_0100);
    rd(5'd13, v); chk("tint exccode", {27'b0, v[6:2]}, 32'd0);
    tick();
    mtc0(5'd11, 32'hFFFF_0000);
    chk("timer cleared", {31'b0, timer_irq_o}, 32'h0);
    instr_valid_i = 1'b1; eret_i = 1'b1; tick(); idle(); tick();

    // external interrupt masked by IE, then taken
    mtc0(5'd12, 32'h0000_0400);
    irq_i = 1'b1;
    instr_valid_i = 1'b1; instr_pc_i = 32'h0040_0180;
    repeat (3) tick();
    chk("irq masked", {31'b0, redirect_o}, 32'h0);
    rd(5'd13, v); chk("irq ip2", {31'b0, v[10]}, 32'h1);
    mtc0(5'd12, 32'h0000_0401);
    chk("irq ie write", {31'b0, redirect_o}, 32'h0);
    instr_valid_i = 1'b1; instr_pc_i = 32'h0040_0200;
    tick(); idle();
    chk("irq redirect_o", {31'b0, redirect_o}, 32'h1);
    rd(5'd14, v); chk("irq epc", v, 32'h0040_0200);
    irq_i = 1'b0;
    tick();
    mtc0(5'd12, 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, v); chk("wrap pre", v, 32'hFFFF_FFFF);
    tick();
    rd(5'd9, v); chk("wrap", v, 32'h0);

    // reset during the redirect pulse
    instr_valid_i = 1'b1; exception_i = 1'b1; cause_sel_i = 2'd0; instr_pc_i = 32'h0040_0300;
    tick(); idle();
    chk("pre-reset pulse", {31'b0, redirect_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid reset redirect_o", {31'b0, redirect_o}, 32'h0);
    chk("mid reset redirect_pc", redirect_pc_o, 32'h0);
    chk("mid reset exl", {31'b0, exl_o}, 32'h0);
    rd(5'd14, v); chk("mid reset epc", v, 32'h0);
    rd(5'd9, v); chk("mid reset count", v, 32'h0);
    tick();
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      idle();
      cp0_addr_i = 5'($urandom_range(8, 15));
      if ($urandom_range(0, 19) == 0) irq_i = ~irq_i;
      instr_valid_i = $urandom_range(0, 1) == 1;
      instr_pc_i = $urandom & 32'hFFFF_FFFC;
      cause_sel_i = 2'($urandom_range(0, 3));
      exception_i = $urandom_range(0, 9) == 0;
      if (!m_redir && instr_valid_i) begin
        if ($urandom_range(0, 19) == 0) eret_i = 1'b1;
        else if ($urandom_range(0, 5) == 0) begin
          cp0_write_i = 1'b1;
          cp0_wdata_i = $urandom;
          case ($urandom_range(0, 5))
            0: cp0_addr_i = 5'd9;
            1: begin cp0_addr_i = 5'd11; cp0_wdata_i = m_count + 32'($urandom_range(0, 40)); end
            2: cp0_addr_i = 5'd12;
            3: cp0_addr_i = 5'd13;
            4: cp0_addr_i = 5'd14;
            default: cp0_addr_i = 5'($urandom_range(0, 31));
          endcase
        end
      end
    end
    tick();
    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_exception_unit.md
# cp0_exception_unit

Coprocessor-0 responder for the multi-cycle 32-bit MIPS core. It consumes the exception, cause-select and CP0-write strobes raised by the instruction decoder, and it services `mtc0`/`mfc0`/`eret`. It holds the Status, Cause, EPC, Count and Compare registers, arbitrates synchronous exceptions against external and timer interrupts, and drives a one-cycle PC redirect to the exception vector or back to EPC.

## Interface
Parameters:
- `VECTOR_ADDR`, default 32'h8000_0180: exception/interrupt handler entry PC.
- `RESET_STATUS`, default 32'h0000_0000: Status value after reset.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid_i` in 1: commit cycle of the current instruction; exceptions and interrupts are sampled only when this is high.
- `instr_pc_i` in 32: PC of the committing instruction.
- `exception_i` in 1: synchronous exception from the decoder.
- `cause_sel_i` in 2: exception source. 00 = overflow, 01 = undefined instruction, 10 = divide-by-zero, 11 = reserved (treated as 01).
- `cp0_write_i` in 1: `mtc0` strobe.
- `cp0_addr_i` in 5: CP0 register number for `mtc0`/`mfc0`.
- `cp0_wdata_i` in 32: `mtc0` data.
- `eret_i` in 1: return-from-exception strobe.
- `irq_i` in 1: asynchronous external interrupt, level-sensitive.
- `cp0_rdata_o` out 32: combinational `mfc0` read of `cp0_addr_i`.
- `redirect_o` out 1: one-cycle pulse; the core loads `redirect_pc_o` and squashes the in-flight instruction.
- `redirect_pc_o` out 32: redirect target.
- `exl_o` out 1: Status.EXL.
- `timer_irq_o` out 1: Cause.IP7.

## Operation
- **Register map.**
  - 9 Count.
  - 11 Compare.
  - 12 Status: bit0 IE, bit1 EXL, bits15:8 IM.
  - 13 Cause: bits6:2 ExcCode, bits15:8 IP, bit31 BD tied 0.
  - 14 EPC.
  - Every other address reads 0; writes to it are ignored.
- **ExcCode values.** Interrupt = 0, undefined instruction = 10, overflow = 12, divide-by-zero = 15.
- **Cause.IP sources.**
  - IP[1:0] are software bits, writable by `mtc0`.
  - IP2 = synchronized `irq_i` (read-only).
  - IP7 = timer pending (read-only).
- **State machine.** States RUN and REDIRECT.
  - RUN → REDIRECT on any accepted event:
    - a synchronous exception,
    - an interrupt,
    - `eret`.
  - REDIRECT lasts exactly one cycle, drives `redirect_o` = 1, then returns to RUN.
  - While in REDIRECT, `instr_valid_i` is ignored.
- **Synchronous exception** (`instr_valid_i` & `exception_i`):
  - Cause.ExcCode ← code for the source.
  - Status.EXL ← 1.
  - Target = `VECTOR_ADDR`.
  - EPC ← `instr_pc_i`, but only if EXL was 0. A nested exception keeps the existing EPC and still updates Cause and redirects.
- **Interrupt.** Taken when all of the following hold:
  - `instr_valid_i` is high,
  - there is no synchronous exception,
  - IE = 1 and EXL = 0,
  - (IP & IM) is non-zero.

  On acceptance: ExcCode = 0, EPC ← `instr_pc_i` (the instruction is squashed and not executed), EXL ← 1, target = `VECTOR_ADDR`.
- **`eret`.** EXL ← 0; target = EPC (the value before this edge).
- **Priority** (highest first): synchronous exception > interrupt > `eret` > `mtc0`. A lower-priority strobe in the same cycle is dropped.
- **`mtc0` writes.**
  - Status: only IE, EXL and IM are written.
  - Cause: only IP[1:0] are written.
  - A Compare write clears the timer-pending bit.
- **Timer.**
  - Count increments every cycle and wraps 32'hFFFF_FFFF → 0.
  - When Count == Compare, the pending bit sets and stays set until Compare is written.
  - A Count write overrides that cycle's increment; counting resumes from the written value on the next cycle.
- **External interrupt.** `irq_i` passes through a 2-flop synchronizer before reaching IP2.

## Timing
- **Reset values** (asynchronous, on `rst_n` low):
  - Status = `RESET_STATUS`.
  - Cause, EPC, Count, Compare, timer pending and synchronizer flops = 0.
  - State = RUN.
  - `redirect_o` = 0, `redirect_pc_o` = 0, `exl_o` = `RESET_STATUS`[1], `timer_irq_o` = 0.
- **Reset mid-REDIRECT** aborts the pulse immediately.
- **Event latency.** The event is sampled at edge N. At edge N, Cause, EPC and EXL update. During cycle N+1, `redirect_o` = 1 and `redirect_pc_o` is valid. `redirect_pc_o` holds its value outside the pulse.
- **`mfc0` reads** are combinational and show register state from before the current edge. A read of Count in the cycle of a Count write returns the old value.
- **`irq_i` latency.** An `irq_i` rising edge reaches Cause.IP2 after 2 edges; the interrupt is taken at the first subsequent valid commit.
- **Timer latency.** The timer pending bit sets at the edge after Count == Compare is observed.

## Structure
- **`cp0_pkg`** holds:
  - CP0 register address constants,
  - ExcCode constants,
  - Status/Cause bit-position constants,
  - the RUN/REDIRECT state enum.
- **Sub-module `cp0_timer`** holds Count, Compare, the pending bit, wrap logic and the write ports.
- The synchronizer and FSM stay inline.

## Test plan
- **Overflow.** Exception with `cause_sel_i`=00 at PC 0x0040_0010 and EXL=0 → next cycle `redirect_o`=1, `redirect_pc_o`=0x8000_0180; EPC=0x0040_0010, Cause.ExcCode=12, `exl_o`=1.
- **Nested exception.** EXL=1, EPC=0x0040_0010, then divide-by-zero at PC 0x8000_0190 → ExcCode=15, EPC unchanged, redirect to 0x8000_0180. A following `eret` → redirect to 0x0040_0010 and `exl_o`=0.
- **Exception vs `mtc0`.** Undefined instruction and `mtc0` to Status with data 0x0000_0401 in the same cycle → ExcCode=10, Status.IM unchanged (write dropped).
- **Timer.** Compare=20 after reset, IE=1, IM7=1 → `timer_irq_o` rises after Count reaches 20. The next valid commit at PC 0x0040_0100 gives ExcCode=0 and EPC=0x0040_0100. Writing Compare clears `timer_irq_o`.
- **External interrupt and wrap.**
  - `irq_i` asserted with IE=0 → IP2 set, no redirect.
  - Set IE=1 → interrupt taken on the next valid commit.
  - Write Count=0xFFFF_FFFF → Count reads 0 two cycles later.
- **Reset mid-pulse.** `rst_n` low during REDIRECT → `redirect_o` falls immediately; all registers return to their reset values.
